fetch_pc_gen: RTL and testbench

- Parametrised next-generation fetch PC generator for the frontend.
- Holds the fetch PC and issues block-fetch requests to channel_arb, up to MAX_OUTSTANDING in flight.
- Handles redirect and interrupt with one-cycle ibuffer flush; in-flight stale responses are discarded by a drop counter.
- Handles unaligned redirect targets generically by exporting the start offset and realigning the next sequential PC.

---
 rtl/frontend_pkg.sv | 17 +
 rtl/fetch_inflight_ctr.sv | 57 +++++
 rtl/fetch_pc_gen.sv | 102 ++++++++++
 tb/tb_fetch_pc_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/frontend_pkg.sv
// Shared frontend types and width helpers for the fetch PC generator.
package frontend_pkg;

   localparam int unsigned PcWidthDefault    = 48;
   localparam int unsigned BlockBytesDefault = 64;

   function automatic int unsigned off_width(input int unsigned block_bytes);
      return $clog2(block_bytes);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

   typedef enum logic [1:0] {StBoot, StRun, StFlush} fetch_state_e;

endpackage

// File: rtl/fetch_inflight_ctr.sv
// Tracks requests in flight for the current stream (live) and for flushed streams (drop),
// and routes in-order completions to keep or drop.
module fetch_inflight_ctr import frontend_pkg::*; #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             fire,
   input  logic             ev,
   input  logic             resp_valid,
   output logic             resp_keep,
   output logic             resp_drop,
   output logic             full,
   output logic [CNT_W-1:0] outstanding
);

   logic [CNT_W-1:0] live_q, live_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             keep_dec;

   always_comb begin
      resp_drop   = resp_valid & (drop_q != '0);
      resp_keep   = resp_valid & (drop_q == '0);
      // A stray completion with nothing live must not underflow the counter
      keep_dec    = resp_keep & (live_q != '0);
      outstanding = live_q + drop_q;
      full        = outstanding >= CNT_W'(MAX_OUTSTANDING);
   end

   always_comb begin
      live_d = live_q;
      drop_d = drop_q;
      if (ev) begin
         // Everything still live, plus a same-cycle fire, becomes stale
         drop_d = drop_q - CNT_W'(resp_drop) + live_q - CNT_W'(keep_dec) + CNT_W'(fire);
         live_d = '0;
      end else begin
         live_d = live_q + CNT_W'(fire) - CNT_W'(keep_dec);
         drop_d = drop_q - CNT_W'(resp_drop);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         live_q <= '0;
         drop_q <= '0;
      end else begin
         live_q <= live_d;
         drop_q <= drop_d;
      end
   end

   resp_valid_when_idle: assert property (@(posedge clock) disable iff (!reset_n)
      !(resp_valid && (outstanding == '0)));

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues block fetches, handles redirect/interrupt with an ibuffer
// flush, and realigns unaligned targets to the next block boundary.
module fetch_pc_gen import frontend_pkg::*; #(
   parameter int unsigned PC_WIDTH        = PcWidthDefault,
   parameter int unsigned BLOCK_BYTES     = BlockBytesDefault,
   parameter int unsigned INDEX_LO        = 3,
   parameter int unsigned INDEX_WIDTH     = 19,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                  clock,
   input  logic                                  reset_n,
   input  logic [PC_WIDTH-1:0]                   boot_addr,
   input  logic                                  interrupt_valid,
   input  logic [PC_WIDTH-1:0]                   interrupt_addr,
   input  logic                                  redirect_valid,
   input  logic [PC_WIDTH-1:0]                   redirect_target,
   input  logic                                  ibuf_ready,
   output logic                                  req_valid,
   input  logic                                  req_ready,
   output logic [INDEX_WIDTH-1:0]                req_index,
   output logic [off_width(BLOCK_BYTES)-1:0]     req_offset,
   input  logic                                  resp_valid,
   output logic                                  resp_keep,
   output logic                                  resp_drop,
   output logic                                  flush_ibuffer,
   output logic [PC_WIDTH-1:0]                   pc,
   output logic [cnt_width(MAX_OUTSTANDING)-1:0] outstanding
);

   localparam int unsigned Off  = off_width(BLOCK_BYTES);
   localparam int unsigned BlkW = PC_WIDTH - Off;
   localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                flush_q;
   logic                ev, ev_acc, fire, full;
   logic [PC_WIDTH-1:0] target;
   logic [BlkW-1:0]     blk_next;

   fetch_inflight_ctr #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CntW)
   ) u_inflight (
      .clock       (clock),
      .reset_n     (reset_n),
      .fire        (fire),
      .ev          (ev_acc),
      .resp_valid  (resp_valid),
      .resp_keep   (resp_keep),
      .resp_drop   (resp_drop),
      .full        (full),
      .outstanding (outstanding)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= StBoot;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   if (ev) state_d = StFlush;
         StFlush: state_d = ev ? StFlush : StRun;
         default: state_d = StBoot;
      endcase
   end

   always_comb begin
      req_valid     = (state_q == StRun) & ibuf_ready & ~full;
      req_index     = pc_q[INDEX_LO+INDEX_WIDTH-1:INDEX_LO];
      req_offset    = pc_q[Off-1:0];
      flush_ibuffer = flush_q;
      pc            = pc_q;
   end

   always_comb begin
      ev       = interrupt_valid | redirect_valid;
      ev_acc   = ev & (state_q != StBoot);
      fire     = req_valid & req_ready;
      target   = interrupt_valid ? interrupt_addr : redirect_target;
      blk_next = pc_q[PC_WIDTH-1:Off] + BlkW'(1);
      pc_d     = pc_q;
      // Redirect wins over the sequential advance of a same-cycle fire
      if (state_q == StBoot) pc_d = boot_addr;
      else if (ev)           pc_d = target;
      else if (fire)         pc_d = {blk_next, {Off{1'b0}}};
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc_q    <= boot_addr;
         flush_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         flush_q <= ev_acc;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed vector bench for fetch_pc_gen: one table row per clock cycle, plus a
// hand-written fill-to-full / drain sequence.
module tb_fetch_pc_gen;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [47:0] boot_addr;
   logic        interrupt_valid;
   logic [47:0] interrupt_addr;
   logic        redirect_valid;
   logic [47:0] redirect_target;
   logic        ibuf_ready;
   logic        req_valid;
   logic        req_ready;
   logic [18:0] req_index;
   logic [5:0]  req_offset;
   logic        resp_valid;
   logic        resp_keep;
   logic        resp_drop;
   logic        flush_ibuffer;
   logic [47:0] pc;
   logic [1:0]  outstanding;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   fetch_pc_gen dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .boot_addr       (boot_addr),
      .interrupt_valid (interrupt_valid),
      .interrupt_addr  (interrupt_addr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .ibuf_ready      (ibuf_ready),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_index       (req_index),
      .req_offset      (req_offset),
      .resp_valid      (resp_valid),
      .resp_keep       (resp_keep),
      .resp_drop       (resp_drop),
      .flush_ibuffer   (flush_ibuffer),
      .pc              (pc),
      .outstanding     (outstanding)
   );

   typedef struct {
      logic        rn, ib, rr, rv, dv;
      logic [47:0] dt;
      logic        iv;
      logic [47:0] ia;
      logic        vld;
      logic [47:0] pc;
      logic        keep, drop, flush;
      logic [1:0]  outs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rn, ib, rr, rv, dv, input logic [47:0] dt,
                               input logic iv, input logic [47:0] ia, input logic vld,
                               input logic [47:0] epc, input logic keep, drop, flush,
                               input logic [1:0] outs);
      vec_t v;
      v.rn = rn; v.ib = ib; v.rr = rr; v.rv = rv; v.dv = dv; v.dt = dt;
      v.iv = iv; v.ia = ia; v.vld = vld; v.pc = epc; v.keep = keep; v.drop = drop;
      v.flush = flush; v.outs = outs;
      return v;
   endfunction

   task automatic chk(input int idx, input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, nm, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] epc;
      int          cyc;
      bit          hit;

      //    rn ib rr rv dv dt              iv ia       vld pc              kp dr fl outs
      vecs.push_back(mk(0, 0, 0, 0, 0, 48'h0,          0, 48'h0, 0, 48'h1000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 0, 48'h1000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h1000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h1040, 0, 0, 0, 2'd1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 0, 48'h1080, 0, 0, 0, 2'd2));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 0, 48'h1080, 1, 0, 0, 2'd2));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h1080, 0, 0, 0, 2'd1));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 0, 48'h10c0, 1, 0, 0, 2'd2));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 1, 48'h10c0, 1, 0, 0, 2'd1));
      vecs.push_back(mk(1, 1, 0, 1, 0, 48'h0,          0, 48'h0, 1, 48'h1100, 1, 0, 0, 2'd1));
      // fire together with an unaligned redirect
      vecs.push_back(mk(1, 1, 1, 0, 1, 48'h2024,       0, 48'h0, 1, 48'h1100, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 0, 48'h2024, 0, 1, 1, 2'd1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h2024, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 48'h0,          0, 48'h0, 1, 48'h2040, 1, 0, 0, 2'd1));
      // two live, then redirect: both become stale
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h2040, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h2080, 0, 0, 0, 2'd1));
      vecs.push_back(mk(1, 1, 1, 0, 1, 48'h3000,       0, 48'h0, 0, 48'h20c0, 0, 0, 0, 2'd2));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 0, 48'h3000, 0, 0, 1, 2'd2));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 0, 48'h3000, 0, 1, 0, 2'd2));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 1, 48'h3000, 0, 1, 0, 2'd1));
      vecs.push_back(mk(1, 1, 0, 1, 0, 48'h0,          0, 48'h0, 1, 48'h3040, 1, 0, 0, 2'd1));
      // same-cycle fire at 0x1040 and redirect to 0x5000
      vecs.push_back(mk(1, 1, 0, 0, 1, 48'h1000,       0, 48'h0, 1, 48'h3040, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 0, 48'h1000, 0, 0, 1, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h1000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 1, 48'h5000,       0, 48'h0, 1, 48'h1040, 0, 0, 0, 2'd1));
      vecs.push_back(mk(1, 1, 1, 1, 0, 48'h0,          0, 48'h0, 0, 48'h5000, 0, 1, 1, 2'd2));
      vecs.push_back(mk(1, 1, 0, 1, 0, 48'h0,          0, 48'h0, 1, 48'h5000, 0, 1, 0, 2'd1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 48'h0,          0, 48'h0, 1, 48'h5000, 0, 0, 0, 2'd0));
      // interrupt beats redirect, then a second event during FLUSH
      vecs.push_back(mk(1, 1, 0, 0, 1, 48'h9000, 1, 48'h8000, 1, 48'h5000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 48'h9000,       0, 48'h0, 0, 48'h8000, 0, 0, 1, 2'd0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 48'h0,          0, 48'h0, 0, 48'h9000, 0, 0, 1, 2'd0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 48'h0,          0, 48'h0, 1, 48'h9000, 0, 0, 0, 2'd0));
      // top-of-space block, 5 cycles of backpressure, then wrap to 0
      vecs.push_back(mk(1, 1, 0, 0, 1, 48'hffff_ffff_ffc0, 0, 48'h0, 1, 48'h9000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 48'h0, 0, 48'h0, 0, 48'hffff_ffff_ffc0, 0, 0, 1, 2'd0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1, 1, 0, 0, 0, 48'h0, 0, 48'h0, 1, 48'hffff_ffff_ffc0, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0, 0, 48'h0, 1, 48'hffff_ffff_ffc0, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 48'h0,          0, 48'h0, 1, 48'h0,    1, 0, 0, 2'd1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 48'h0,          0, 48'h0, 0, 48'h0,    0, 0, 0, 2'd0));
      // reset mid-operation, and a redirect ignored during BOOT
      vecs.push_back(mk(1, 1, 1, 0, 0, 48'h0,          0, 48'h0, 1, 48'h0,    0, 0, 0, 2'd0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 48'h0,          0, 48'h0, 1, 48'h40,   0, 0, 0, 2'd1));
      vecs.push_back(mk(1, 1, 0, 0, 1, 48'h7000,       0, 48'h0, 0, 48'h1000, 0, 0, 0, 2'd0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 48'h0,          0, 48'h0, 1, 48'h1000, 0, 0, 0, 2'd0));

      reset_n = 1'b0; boot_addr = 48'h1000; ibuf_ready = 1'b0; req_ready = 1'b0;
      resp_valid = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      interrupt_valid = 1'b0; interrupt_addr = '0;
      repeat (2) @(posedge clock);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         reset_n         = vecs[i].rn;
         ibuf_ready      = vecs[i].ib;
         req_ready       = vecs[i].rr;
         resp_valid      = vecs[i].rv;
         redirect_valid  = vecs[i].dv;
         redirect_target = vecs[i].dt;
         interrupt_valid = vecs[i].iv;
         interrupt_addr  = vecs[i].ia;
         #1;
         epc = vecs[i].pc;
         n_vec++;
         chk(i, "req_valid",     64'(req_valid),     64'(vecs[i].vld));
         chk(i, "pc",            64'(pc),            64'(epc));
         chk(i, "req_index",     64'(req_index),     64'(epc[21:3]));
         chk(i, "req_offset",    64'(req_offset),    64'(epc[5:0]));
         chk(i, "resp_keep",     64'(resp_keep),     64'(vecs[i].keep));
         chk(i, "resp_drop",     64'(resp_drop),     64'(vecs[i].drop));
         chk(i, "flush_ibuffer", 64'(flush_ibuffer), 64'(vecs[i].flush));
         chk(i, "outstanding",   64'(outstanding),   64'(vecs[i].outs));
      end

      // Fill to MAX_OUTSTANDING from pc 0x1000, then drain with backpressure held
      @(negedge clock);
      redirect_valid = 1'b0; ibuf_ready = 1'b1; req_ready = 1'b1; resp_valid = 1'b0;
      hit = 1'b0;
      cyc = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (outstanding == 2'd2) begin
            hit = 1'b1;
            break;
         end
         cyc++;
         @(negedge clock);
      end
      n_vec++;
      chk(100, "fill_reached_full", 64'(hit), 64'd1);
      chk(100, "fill_cycles",       64'(cyc), 64'd2);
      chk(100, "full_req_valid",    64'(req_valid), 64'd0);
      chk(100, "full_pc",           64'(pc), 64'h1080);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      #1;
      n_vec++;
      chk(101, "drain_keep", 64'(resp_keep), 64'd1);
      @(negedge clock);
      #1;
      n_vec++;
      chk(102, "drain_outstanding", 64'(outstanding), 64'd1);
      chk(102, "drain_keep",        64'(resp_keep), 64'd1);
      @(negedge clock);
      resp_valid = 1'b0;
      #1;
      n_vec++;
      chk(103, "drained_outstanding", 64'(outstanding), 64'd0);
      chk(103, "drained_req_valid",   64'(req_valid), 64'd1);
      chk(103, "drained_index",       64'(req_index), 64'h210);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
